// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_pkg
// Purpose : Shared write-op encodings and the post-write value function used
//           by both the storage cells and the read bypass path.
// Rev     : 1.0  initial release
// ============================================================================
package reg_file_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_CLR  = 2'b11
    } wr_op_e;

    // Widest register supported; callers zero-extend into this and keep
    // only their own low WIDTH bits, so the increment wraps modulo 2^WIDTH.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    // Value a register holds after a write of 'op' with old contents old_val.
    function automatic word_t next_value(input wr_op_e op,
                                         input word_t  old_val,
                                         input word_t  din);
        word_t r;
        case (op)
            OP_LOAD: r = din;
            OP_INC:  r = old_val + word_t'(1);
            OP_CLR:  r = '0;
            default: r = old_val;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_ops_reg_cell.sv
`default_nettype none
// ============================================================================
// Module  : reg_cell
// Purpose : One WIDTH-bit register with async active-low clear, applying a
//           load / increment / clear op when write-enabled.
// Rev     : 1.0  initial release
// ============================================================================
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    word_t            old_ext;
    word_t            din_ext;
    word_t            next_ext;

    // Next value: apply the op only when this cell is the write target.
    always_comb begin
        old_ext              = '0;
        old_ext[WIDTH-1:0]   = val_q;
        din_ext              = '0;
        din_ext[WIDTH-1:0]   = din_i;
        next_ext             = next_value(wr_op_e'(op_i), old_ext, din_ext);
        val_d                = we_i ? next_ext[WIDTH-1:0] : val_q;
    end

    // Bits above WIDTH (increment carry) are deliberately discarded.
    if (WIDTH < MAX_W) begin : g_tail
        logic unused_tail;
        assign unused_tail = |next_ext[MAX_W-1:WIDTH];
    end

    // Storage register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_ops.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_ops
// Purpose : DEPTH x WIDTH register bank with one op-carrying write port
//           (load / increment / clear), two independent registered read
//           ports with write-first bypass, and an increment-wrap pulse.
// Rev     : 1.0  initial release
// ============================================================================
module reg_file_ops
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             CLOCK_50,
    input  logic             rest,
    input  logic [1:0]       wr_op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_valid_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_b,
    output logic             inc_wrap
);

    // Address space rounded up to a power of two; slots past DEPTH read 0.
    localparam int NSLOT = 1 << AW;

    logic [WIDTH-1:0] cell_q [NSLOT];

    logic             wr_eff;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_next;
    word_t            wr_old_ext;
    word_t            wr_din_ext;
    word_t            wr_next_ext;

    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             rd_valid_a_q, rd_valid_b_q;
    logic             inc_wrap_q, inc_wrap_d;

    // An address is backed by real storage: inside DEPTH and not a pinned r0.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    // Storage cells for live slots, constant zero for the padding slots.
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < DEPTH) begin : g_cell
            reg_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk_i  (CLOCK_50),
                .rst_ni (rest),
                .we_i   (wr_eff && (wr_addr == AW'(i))),
                .op_i   (wr_op),
                .din_i  (wr_data),
                .q_o    (cell_q[i])
            );
        end else begin : g_pad
            assign cell_q[i] = '0;
        end
    end

    // Write decode and the value the target will hold after this edge.
    always_comb begin
        wr_eff                  = (wr_op != OP_NONE) && addr_live(wr_addr);
        wr_old                  = cell_q[wr_addr];
        wr_old_ext              = '0;
        wr_old_ext[WIDTH-1:0]   = wr_old;
        wr_din_ext              = '0;
        wr_din_ext[WIDTH-1:0]   = wr_data;
        wr_next_ext             = next_value(wr_op_e'(wr_op), wr_old_ext, wr_din_ext);
        wr_next                 = wr_next_ext[WIDTH-1:0];
        inc_wrap_d              = wr_eff && (wr_op == OP_INC) && (&wr_old);
    end

    if (WIDTH < MAX_W) begin : g_tail
        logic unused_tail;
        assign unused_tail = |wr_next_ext[MAX_W-1:WIDTH];
    end

    // Read muxes with write-first bypass; dead addresses read as zero.
    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en_a) begin
            if (!addr_live(rd_addr_a)) begin
                rd_data_a_d = '0;
            end else if (wr_eff && (wr_addr == rd_addr_a)) begin
                rd_data_a_d = wr_next;
            end else begin
                rd_data_a_d = cell_q[rd_addr_a];
            end
        end
        if (rd_en_b) begin
            if (!addr_live(rd_addr_b)) begin
                rd_data_b_d = '0;
            end else if (wr_eff && (wr_addr == rd_addr_b)) begin
                rd_data_b_d = wr_next;
            end else begin
                rd_data_b_d = cell_q[rd_addr_b];
            end
        end
    end

    // Output registers; reset cancels any pending read and wrap pulse.
    always_ff @(posedge CLOCK_50 or negedge rest) begin
        if (!rest) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            inc_wrap_q   <= 1'b0;
        end else begin
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_en_a;
            rd_valid_b_q <= rd_en_b;
            inc_wrap_q   <= inc_wrap_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign inc_wrap   = inc_wrap_q;

endmodule
`default_nettype wire

// File: doc/reg_file_ops.md
Name: reg_file_ops

Overview:
- Parametrised successor to the single 16-bit data register of the simple processor.
- DEPTH registers of WIDTH bits, with one write port carrying an operation: load, increment or clear.
- Two independent registered read ports, write-first bypass, and a wrap flag on increment.
- Serves as the processor's general register bank; the program counter can live in any entry and use the increment op.

Parameters:
- WIDTH, 16, data width of every register.
- DEPTH, 8, number of registers (2..64; need not be a power of two).
- AW, $clog2(DEPTH), address width; derived, never overridden.
- ZERO_REG, 0: if 1, register 0 always reads 0 and all writes to it are ignored.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- rest  in  1  reset, asynchronous, active-low.
- wr_op  in  2  write operation: 00 none, 01 load, 10 increment, 11 clear.
- wr_addr  in  AW  target register.
- wr_data  in  WIDTH  load value; used only when wr_op=01.
- rd_en_a  in  1  read request, port A.
- rd_addr_a  in  AW  read address, port A.
- rd_data_a  out  WIDTH  registered read data, port A.
- rd_valid_a  out  1  one-cycle pulse: rd_data_a updated.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: identical to port A, for port B.
- inc_wrap  out  1  one-cycle pulse: an increment wrapped all-ones to zero.

Behaviour:
- Reset: clock and reset are one clock (CLOCK_50) with asynchronous, active-low reset (rest).
  - rest=0 immediately clears all registers, rd_data_a/b, rd_valid_a/b and inc_wrap to 0, regardless of the clock.
  - Release is sampled at the next rising edge.
- Write, rising edge, target wr_addr:
  - 01: reg <= wr_data.
  - 10: reg <= reg+1, modulo 2^WIDTH.
  - 11: reg <= 0.
  - 00: no change.
- Write is ignored when wr_addr >= DEPTH, or when ZERO_REG=1 and wr_addr=0.
- inc_wrap: set to 1 for exactly the cycle after an effective increment whose old value was all-ones; 0 otherwise. An ignored increment never pulses.
- Read (per port, ports fully independent):
  - If rd_en=1 at edge k, rd_data takes the value the addressed register holds after edge k's write (write-first bypass). This covers load, increment (old+1) and clear.
  - rd_valid=1 for the cycle after edge k.
  - Latency 1 cycle; a new read can issue every cycle.
- rd_en=0: rd_data holds its last value; rd_valid=0.
- Address >= DEPTH, or address 0 with ZERO_REG=1: rd_data=0 with rd_valid=1.
- Both ports reading the same address, including the one being written, return identical data.
- Reset asserted mid-read: the pending rd_valid is cancelled; no read survives reset.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package reg_file_pkg holds:
  - wr_op encodings OP_NONE=2'b00, OP_LOAD=2'b01, OP_INC=2'b10, OP_CLR=2'b11;
  - a function next_value(op, old, din) returning the post-write value, used by both storage and bypass logic.
- One sub-module, reg_cell: a single WIDTH register with async active-low clear, a write enable and an op input, built from next_value.
- The top instantiates DEPTH reg_cells via generate, plus the read muxes, bypass and wrap logic.

Test Plan:
- Reset then release, read A addr 3 -> rd_data_a=16'h0000, rd_valid_a pulse 1 cycle; inc_wrap=0.
- Load 16'h00F1 to r2 at edge k, read A r2 at edge k+1 -> 16'h00F1. Same-cycle load 16'h0013 to r5 with read B r5 -> rd_data_b=16'h0013 one cycle later (bypass).
- Load r4=16'hFFFF, then increment r4 with read A r4 in the same cycle -> rd_data_a=16'h0000 and inc_wrap=1 for one cycle. A second increment -> 16'h0001 with inc_wrap=0.
- ZERO_REG=1: load 16'h1234 to r0, read A and B r0 -> both 16'h0000. Clear r1 after loading 16'h0014 -> reads 16'h0000.
- DEPTH=6: load to addr 7 then read addr 7 -> 16'h0000 with rd_valid; r0..r5 unchanged.
- Load r1=16'h0012, issue read r1, drive rest=0 mid-cycle before the edge -> rd_data/rd_valid immediately 0. After release, read r1 -> 16'h0000.
